glyph_serializer: RTL and testbench

GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

---
 rtl/charmatrix_pkg.sv | 130 +++++++++++++
 rtl/char_rom.sv | 28 ++
 rtl/glyph_serializer.sv | 158 +++++++++++++++
 tb/tb_glyph_serializer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charmatrix_pkg.sv
// charmatrix_pkg
// Shared constants for the 5x7 dot-matrix character path: character code
// width, glyph geometry, the printable code range, the serializer FSM state
// type and the glyph table behind char_rom.
//
// Glyph packing: 7 rows of 5 columns, row 0 (top) in bits [34:30], row 6
// (bottom) in bits [4:0]. Within a row the leftmost dot is the MSB, so glyph
// bit 34 is the top-left dot and is the first bit shifted out.
package charmatrix_pkg;

    localparam int CHAR_W     = 7;
    localparam int GLYPH_ROWS = 7;
    localparam int GLYPH_COLS = 5;
    localparam int GLYPH_BITS = GLYPH_ROWS * GLYPH_COLS;

    localparam logic [CHAR_W-1:0] ADDR_MIN = 7'd32;
    localparam logic [CHAR_W-1:0] ADDR_MAX = 7'd126;

    // Entries 0..94 cover codes 32..126; entry 95 is the fallback glyph
    // (hollow box) shown for any code outside the printable range.
    localparam int ROM_DEPTH    = 96;
    localparam int FALLBACK_IDX = 95;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam logic [GLYPH_BITS-1:0] GLYPH_ROM [0:ROM_DEPTH-1] = '{
        {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},  // 0x20 ' '
        {5'h04, 5'h04, 5'h04, 5'h04, 5'h00, 5'h00, 5'h04},  // 0x21 '!'
        {5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00},  // 0x22 '"'
        {5'h0A, 5'h0A, 5'h1F, 5'h0A, 5'h1F, 5'h0A, 5'h0A},  // 0x23 '#'
        {5'h04, 5'h0F, 5'h14, 5'h0E, 5'h05, 5'h1E, 5'h04},  // 0x24 '$'
        {5'h18, 5'h19, 5'h02, 5'h04, 5'h08, 5'h13, 5'h03},  // 0x25 '%'
        {5'h0C, 5'h12, 5'h14, 5'h08, 5'h15, 5'h12, 5'h0D},  // 0x26 '&'
        {5'h0C, 5'h04, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00},  // 0x27 '''
        {5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02},  // 0x28 '('
        {5'h08, 5'h04, 5'h02, 5'h02, 5'h02, 5'h04, 5'h08},  // 0x29 ')'
        {5'h00, 5'h04, 5'h15, 5'h0E, 5'h15, 5'h04, 5'h00},  // 0x2A '*'
        {5'h00, 5'h04, 5'h04, 5'h1F, 5'h04, 5'h04, 5'h00},  // 0x2B '+'
        {5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h04, 5'h08},  // 0x2C ','
        {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00},  // 0x2D '-'
        {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C},  // 0x2E '.'
        {5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00},  // 0x2F '/'
        {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},  // 0x30 '0'
        {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // 0x31 '1'
        {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},  // 0x32 '2'
        {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},  // 0x33 '3'
        {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},  // 0x34 '4'
        {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},  // 0x35 '5'
        {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},  // 0x36 '6'
        {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},  // 0x37 '7'
        {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},  // 0x38 '8'
        {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},  // 0x39 '9'
        {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00},  // 0x3A ':'
        {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h04, 5'h08},  // 0x3B ';'
        {5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02},  // 0x3C '<'
        {5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00},  // 0x3D '='
        {5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04, 5'h08},  // 0x3E '>'
        {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h00, 5'h04},  // 0x3F '?'
        {5'h0E, 5'h11, 5'h01, 5'h0D, 5'h15, 5'h15, 5'h0E},  // 0x40 '@'
        {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11},  // 0x41 'A'
        {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E},  // 0x42 'B'
        {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E},  // 0x43 'C'
        {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C},  // 0x44 'D'
        {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F},  // 0x45 'E'
        {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10},  // 0x46 'F'
        {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F},  // 0x47 'G'
        {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11},  // 0x48 'H'
        {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // 0x49 'I'
        {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C},  // 0x4A 'J'
        {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11},  // 0x4B 'K'
        {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F},  // 0x4C 'L'
        {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11},  // 0x4D 'M'
        {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11},  // 0x4E 'N'
        {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},  // 0x4F 'O'
        {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10},  // 0x50 'P'
        {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D},  // 0x51 'Q'
        {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11},  // 0x52 'R'
        {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E},  // 0x53 'S'
        {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04},  // 0x54 'T'
        {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},  // 0x55 'U'
        {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04},  // 0x56 'V'
        {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A},  // 0x57 'W'
        {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11},  // 0x58 'X'
        {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04},  // 0x59 'Y'
        {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F},  // 0x5A 'Z'
        {5'h0E, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h0E},  // 0x5B '['
        {5'h00, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00},  // 0x5C backslash
        {5'h0E, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0E},  // 0x5D ']'
        {5'h04, 5'h0A, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00},  // 0x5E '^'
        {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F},  // 0x5F '_'
        {5'h08, 5'h04, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00},  // 0x60 '`'
        {5'h00, 5'h00, 5'h0E, 5'h01, 5'h0F, 5'h11, 5'h0F},  // 0x61 'a'
        {5'h10, 5'h10, 5'h16, 5'h19, 5'h11, 5'h11, 5'h1E},  // 0x62 'b'
        {5'h00, 5'h00, 5'h0E, 5'h10, 5'h10, 5'h11, 5'h0E},  // 0x63 'c'
        {5'h01, 5'h01, 5'h0D, 5'h13, 5'h11, 5'h11, 5'h0F},  // 0x64 'd'
        {5'h00, 5'h00, 5'h0E, 5'h11, 5'h1F, 5'h10, 5'h0E},  // 0x65 'e'
        {5'h06, 5'h09, 5'h08, 5'h1C, 5'h08, 5'h08, 5'h08},  // 0x66 'f'
        {5'h00, 5'h0F, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E},  // 0x67 'g'
        {5'h10, 5'h10, 5'h16, 5'h19, 5'h11, 5'h11, 5'h11},  // 0x68 'h'
        {5'h04, 5'h00, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h0E},  // 0x69 'i'
        {5'h02, 5'h00, 5'h06, 5'h02, 5'h02, 5'h12, 5'h0C},  // 0x6A 'j'
        {5'h10, 5'h10, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12},  // 0x6B 'k'
        {5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},  // 0x6C 'l'
        {5'h00, 5'h00, 5'h1A, 5'h15, 5'h15, 5'h11, 5'h11},  // 0x6D 'm'
        {5'h00, 5'h00, 5'h16, 5'h19, 5'h11, 5'h11, 5'h11},  // 0x6E 'n'
        {5'h00, 5'h00, 5'h0E, 5'h11, 5'h11, 5'h11, 5'h0E},  // 0x6F 'o'
        {5'h00, 5'h00, 5'h1E, 5'h11, 5'h1E, 5'h10, 5'h10},  // 0x70 'p'
        {5'h00, 5'h00, 5'h0D, 5'h13, 5'h0F, 5'h01, 5'h01},  // 0x71 'q'
        {5'h00, 5'h00, 5'h16, 5'h19, 5'h10, 5'h10, 5'h10},  // 0x72 'r'
        {5'h00, 5'h00, 5'h0E, 5'h10, 5'h0E, 5'h01, 5'h1E},  // 0x73 's'
        {5'h08, 5'h08, 5'h1C, 5'h08, 5'h08, 5'h09, 5'h06},  // 0x74 't'
        {5'h00, 5'h00, 5'h11, 5'h11, 5'h11, 5'h13, 5'h0D},  // 0x75 'u'
        {5'h00, 5'h00, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04},  // 0x76 'v'
        {5'h00, 5'h00, 5'h11, 5'h11, 5'h15, 5'h15, 5'h0A},  // 0x77 'w'
        {5'h00, 5'h00, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11},  // 0x78 'x'
        {5'h00, 5'h00, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E},  // 0x79 'y'
        {5'h00, 5'h00, 5'h1F, 5'h02, 5'h04, 5'h08, 5'h1F},  // 0x7A 'z'
        {5'h02, 5'h04, 5'h04, 5'h08, 5'h04, 5'h04, 5'h02},  // 0x7B '{'
        {5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04},  // 0x7C '|'
        {5'h08, 5'h04, 5'h04, 5'h02, 5'h04, 5'h04, 5'h08},  // 0x7D '}'
        {5'h00, 5'h00, 5'h08, 5'h15, 5'h02, 5'h00, 5'h00},  // 0x7E '~'
        {5'h1F, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1F}   // fallback box
    };

endpackage

// File: rtl/char_rom.sv
// char_rom
// Combinational glyph lookup. Printable codes 32..126 map to their own
// glyph; every other code maps to the fallback glyph.
//
// Ports:
//   addr   in  [6:0]   character code
//   glyph  out [34:0]  packed 5x7 glyph, bit 34 = top-left dot
module char_rom
    import charmatrix_pkg::*;
(
    input  logic [CHAR_W-1:0]     addr,
    output logic [GLYPH_BITS-1:0] glyph
);

    logic [CHAR_W-1:0] idx;

    // NOTE: the glyph table is constant data, not storage, so it has no reset;
    // only state that must start from a known value gets one.
    always_comb begin
        if (addr >= ADDR_MIN && addr <= ADDR_MAX) begin
            idx = addr - ADDR_MIN;
        end else begin
            idx = CHAR_W'(FALLBACK_IDX);
        end
        glyph = GLYPH_ROM[idx];
    end

endmodule

// File: rtl/glyph_serializer.sv
// glyph_serializer
// Accepts one ASCII code at a time, fetches its 5x7 glyph from char_rom and
// shifts the 35 dots out MSB first to an external shift-register chain,
// then pulses the chain's storage latch.
//
// Frame timing (D = CLK_DIV):
//   LOAD   1 cycle     glyph captured, first bit placed on sdata
//   SHIFT  70*D cycles 35 bits, each D cycles sclk low then D cycles high
//   LATCH  D cycles    slatch high, sclk low
//
// Ports:
//   clk         in        system clock, rising edge
//   rst         in        synchronous active-high reset
//   char_in     in  [6:0] character code, sampled on acceptance
//   char_valid  in        char_in is valid
//   char_ready  out       high only in IDLE
//   sclk        out       serial shift clock
//   sdata       out       serial data, stable across sclk rising edges
//   slatch      out       storage-latch strobe after the last bit
//   busy        out       inverse of char_ready
module glyph_serializer
    import charmatrix_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              sclk,
    output logic              sdata,
    output logic              slatch,
    output logic              busy
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(GLYPH_BITS - 1);

    state_e                state_q,  state_d;
    logic [CHAR_W-1:0]     addr_q,   addr_d;
    logic [GLYPH_BITS-1:0] shift_q,  shift_d;
    logic [7:0]            div_q,    div_d;
    logic [5:0]            bit_q,    bit_d;
    logic                  sclk_q,   sclk_d;
    logic                  sdata_q,  sdata_d;
    logic                  slatch_q, slatch_d;

    logic [GLYPH_BITS-1:0] rom_glyph;

    char_rom u_char_rom (
        .addr  (addr_q),
        .glyph (rom_glyph)
    );

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;
        slatch_d = slatch_q;

        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    addr_d  = char_in;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Bit 34 goes straight to sdata; the shift register keeps
                // the remaining bits left-aligned for the following bits.
                sdata_d = rom_glyph[GLYPH_BITS-1];
                shift_d = {rom_glyph[GLYPH_BITS-2:0], 1'b0};
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of a high phase: sclk falls, and this is the
                        // only point where sdata may move to the next bit.
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            sdata_d  = 1'b0;
                            slatch_d = 1'b1;
                            state_d  = ST_LATCH;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            sdata_d = shift_q[GLYPH_BITS-1];
                            shift_d = {shift_q[GLYPH_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    bit_d    = '0;
                    slatch_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            slatch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            slatch_q <= slatch_d;
        end
    end

    assign char_ready = (state_q == ST_IDLE);
    assign busy       = ~char_ready;
    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign slatch     = slatch_q;

endmodule

// File: tb/tb_glyph_serializer.sv
// tb_glyph_serializer
// Two instances share one clock: dut0 at CLK_DIV=4 and dut1 at CLK_DIV=1.
// `sel` chooses which instance the frame tasks drive and observe. Frames are
// observed like the external chain would: dots sampled on sclk rising edges,
// slatch width and busy duration counted, and compared with expectations
// from fixed glyph constants or from a code-to-glyph model.
module tb_glyph_serializer;
    import charmatrix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [6:0] char_in0, char_in1;
    logic       char_valid0, char_valid1;
    logic       char_ready0, sclk0, sdata0, slatch0, busy0;
    logic       char_ready1, sclk1, sdata1, slatch1, busy1;

    glyph_serializer #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst0), .char_in(char_in0), .char_valid(char_valid0),
        .char_ready(char_ready0), .sclk(sclk0), .sdata(sdata0),
        .slatch(slatch0), .busy(busy0)
    );

    glyph_serializer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .char_in(char_in1), .char_valid(char_valid1),
        .char_ready(char_ready1), .sclk(sclk1), .sdata(sdata1),
        .slatch(slatch1), .busy(busy1)
    );

    logic sel;
    wire  m_sclk   = sel ? sclk1       : sclk0;
    wire  m_sdata  = sel ? sdata1      : sdata0;
    wire  m_slatch = sel ? slatch1     : slatch0;
    wire  m_busy   = sel ? busy1       : busy0;
    wire  m_ready  = sel ? char_ready1 : char_ready0;

    int total = 0;
    int bad   = 0;

    localparam logic [34:0] G_A     = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
    localparam logic [34:0] G_H     = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
    localparam logic [34:0] G_I     = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
    localparam logic [34:0] G_BOX   = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1F};
    localparam logic [34:0] G_BLANK = 35'd0;

    // Reference glyph for any code: printable codes index the glyph table
    // from 0x20, everything else shows the box.
    function automatic logic [34:0] model_glyph(input logic [6:0] c);
        if (c < 7'd32 || c > 7'd126) return G_BOX;
        return GLYPH_ROM[int'(c) - 32];
    endfunction

    task automatic drive(input logic [6:0] c, input logic v);
        if (sel) begin
            char_in1 = c; char_valid1 = v;
        end else begin
            char_in0 = c; char_valid0 = v;
        end
    endtask

    // Runs one frame on the selected instance, starting at a negedge. When
    // pre_accepted is set the code was already presented by the previous
    // frame's hold. While busy, char_in/char_valid are scrambled, which must
    // have no effect. At the first idle negedge, next_c/hold are presented.
    task automatic do_frame(input string name, input logic [6:0] c,
                            input logic [34:0] exp, input bit pre_accepted,
                            input bit hold, input logic [6:0] next_c);
        int d, n, nbits, hi, lat, pulses;
        bit sd_bad, rdy_bad, ovl_bad;
        logic ps, pd, pl;
        logic [34:0] got;
        d = sel ? 1 : 4;
        n = 0; nbits = 0; hi = 0; lat = 0; pulses = 0;
        sd_bad = 0; rdy_bad = 0; ovl_bad = 0;
        ps = 1'b0; pd = 1'b0; pl = 1'b0; got = '0;

        if (!pre_accepted) drive(c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (m_busy !== 1'b1) begin
            bad++; $display("FAIL %s accept: busy=%b want 1", name, m_busy);
        end

        while (m_busy === 1'b1 && n < 4000) begin
            n++;
            if (m_sclk === 1'b1 && ps === 1'b0) begin
                if (nbits < 35) got[34-nbits] = m_sdata;
                nbits++;
            end
            if (m_sclk === 1'b1) hi++;
            // sdata may only move when sclk falls, or on the first SHIFT cycle
            if (m_sdata !== pd && !(ps === 1'b1 && m_sclk === 1'b0) && n != 2) sd_bad = 1;
            if (m_slatch === 1'b1) begin
                lat++;
                if (pl !== 1'b1) pulses++;
                if (m_sclk !== 1'b0) ovl_bad = 1;
            end
            if (m_ready !== 1'b0) rdy_bad = 1;
            drive(7'($urandom), 1'($urandom));
            ps = m_sclk; pd = m_sdata; pl = m_slatch;
            @(negedge clk);
        end
        drive(next_c, hold);

        total++;
        if (n != 1 + 71*d) begin
            bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n, 1 + 71*d);
        end
        total++;
        if (nbits != 35) begin
            bad++; $display("FAIL %s sclk_rises: got %0d want 35", name, nbits);
        end
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL %s glyph: got %h want %h (code %h)", name, got, exp, c);
        end
        total++;
        if (hi != 35*d) begin
            bad++; $display("FAIL %s sclk_high_cycles: got %0d want %0d", name, hi, 35*d);
        end
        total++;
        if (lat != d || pulses != 1) begin
            bad++; $display("FAIL %s slatch: width %0d pulses %0d want %0d/1", name, lat, pulses, d);
        end
        total++;
        if (sd_bad || ovl_bad || rdy_bad) begin
            bad++; $display("FAIL %s protocol: sdata_move=%0d latch_sclk=%0d ready_busy=%0d want 0/0/0",
                            name, sd_bad, ovl_bad, rdy_bad);
        end
        total++;
        if ({m_sclk, m_sdata, m_slatch, m_ready} !== 4'b0001) begin
            bad++; $display("FAIL %s idle_outputs: sclk/sdata/slatch/ready=%b want 0001",
                            name, {m_sclk, m_sdata, m_slatch, m_ready});
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        char_in0 = '0; char_in1 = '0; char_valid0 = 1'b0; char_valid1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({sclk0, sdata0, slatch0, busy0, char_ready0} !== 5'b00001) begin
            bad++; $display("FAIL reset_dut0: sclk/sdata/slatch/busy/ready=%b want 00001",
                            {sclk0, sdata0, slatch0, busy0, char_ready0});
        end
        total++;
        if ({sclk1, sdata1, slatch1, busy1, char_ready1} !== 5'b00001) begin
            bad++; $display("FAIL reset_dut1: sclk/sdata/slatch/busy/ready=%b want 00001",
                            {sclk1, sdata1, slatch1, busy1, char_ready1});
        end
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        total++;
        if (char_ready0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", char_ready0, busy0);
        end
    endtask

    task automatic test_letter_a();
        sel = 1'b0;
        do_frame("char_A", 7'h41, G_A, 0, 0, 7'h00);
    endtask

    task automatic test_fallback();
        sel = 1'b0;
        do_frame("code_07", 7'h07, G_BOX, 0, 0, 7'h00);
        do_frame("code_7F", 7'h7F, G_BOX, 0, 0, 7'h00);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_frame("b2b_H", 7'h48, G_H, 0, 1, 7'h49);
        do_frame("b2b_I", 7'h49, G_I, 1, 0, 7'h00);
    endtask

    task automatic test_abort_shift();
        int rises, k;
        logic prev;
        sel = 1'b0;
        drive(7'h41, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(7'h00, 1'b0);
        rises = 0; k = 0; prev = 1'b0;
        // Stop in the high phase of bit 17 (the 18th rising edge).
        while (rises < 18 && k < 2000) begin
            if (sclk0 === 1'b1 && prev === 1'b0) rises++;
            prev = sclk0;
            k++;
            if (rises < 18) @(negedge clk);
        end
        total++;
        if (rises != 18 || sclk0 !== 1'b1) begin
            bad++; $display("FAIL abort_reach_bit17: rises=%0d sclk=%b want 18/1", rises, sclk0);
        end
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        total++;
        if ({sclk0, sdata0, slatch0, char_ready0, busy0} !== 5'b00010) begin
            bad++; $display("FAIL abort_shift_outputs: sclk/sdata/slatch/ready/busy=%b want 00010",
                            {sclk0, sdata0, slatch0, char_ready0, busy0});
        end
        k = 0;
        repeat (300) begin
            @(negedge clk);
            if (sclk0 !== 1'b0 || slatch0 !== 1'b0 || busy0 !== 1'b0) k++;
        end
        total++;
        if (k != 0) begin
            bad++; $display("FAIL abort_shift_quiet: %0d active cycles want 0", k);
        end
        do_frame("abort_recover_A", 7'h41, G_A, 0, 0, 7'h00);
    endtask

    task automatic test_abort_latch();
        int k, act;
        sel = 1'b0;
        drive(7'h48, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(7'h00, 1'b0);
        k = 0;
        while (slatch0 !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (slatch0 !== 1'b1) begin
            bad++; $display("FAIL abort_reach_latch: slatch=%b want 1", slatch0);
        end
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        act = 0;
        repeat (20) begin
            if (slatch0 !== 1'b0 || sclk0 !== 1'b0 || busy0 !== 1'b0) act++;
            @(negedge clk);
        end
        total++;
        if (act != 0) begin
            bad++; $display("FAIL abort_latch_quiet: %0d active cycles want 0", act);
        end
    endtask

    task automatic test_div1_blank();
        sel = 1'b1;
        do_frame("div1_space", 7'h20, G_BLANK, 0, 0, 7'h00);
    endtask

    task automatic test_random();
        logic [6:0] c, c2;
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = 7'($urandom_range(0, 127));
            do_frame("rand_div4", c, model_glyph(c), 0, 0, 7'h00);
        end
        sel = 1'b1;
        for (int i = 0; i < 12; i++) begin
            c = 7'($urandom_range(0, 127));
            do_frame("rand_div1", c, model_glyph(c), 0, 0, 7'h00);
        end
        for (int i = 0; i < 4; i++) begin
            c  = 7'($urandom_range(0, 127));
            c2 = 7'($urandom_range(0, 127));
            do_frame("rand_b2b_first", c, model_glyph(c), 0, 1, c2);
            do_frame("rand_b2b_second", c2, model_glyph(c2), 1, 0, 7'h00);
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_letter_a();
        test_fallback();
        test_back_to_back();
        test_abort_shift();
        test_abort_latch();
        test_div1_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
